uart_rx_cfg: RTL and testbench

//  Parametrised successor to the SoC UART receiver: run-time frame format (5-8 data bits,

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 50 +++++
 rtl/uart_rx_cfg.sv | 146 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Frame-format struct is latched once per frame at start-bit detection.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRK_WAIT
  } state_t;

  typedef struct packed {
    logic [1:0] data_len;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
  } cfg_t;

  localparam int MIN_DATA_BITS = 5;
  // Majority taps sit at P/2-SMP_PRE, P/2, P/2+SMP_POST within a bit
  localparam int SMP_PRE  = 1;
  localparam int SMP_POST = 1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with 3-tap majority vote; strobe fires on the last tap cycle.
// Latency: bit_stb is combinational at edge P/2+1; no backpressure, free-running while !arm.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_s,
  input  logic               arm,
  input  logic [PRESC_W-1:0] prescale,
  output logic               bit_val,
  output logic               bit_stb
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] smp_a;
  logic [PRESC_W-1:0] smp_c;
  logic               s_a;
  logic               s_b;

  assign half  = prescale >> 1;
  assign smp_a = half - PRESC_W'(SMP_PRE);
  assign smp_c = half + PRESC_W'(SMP_POST);

  // While armed the start edge is cycle 0 of the bit, so the first counted cycle is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s_a <= 1'b0;
      s_b <= 1'b0;
    end else begin
      if (arm) begin
        cnt <= PRESC_W'(1);
      end else if (cnt == prescale - PRESC_W'(1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRESC_W'(1);
      end
      if (!arm && cnt == smp_a) s_a <= rx_s;
      if (!arm && cnt == half)  s_b <= rx_s;
    end
  end

  assign bit_stb = !arm && (cnt == smp_c);
  assign bit_val = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time frame format, majority sampling and break detection.
// Flags/P_DATA register one cycle after DONE; no backpressure, each frame yields one pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  parameter int SYNC_ST = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [1:0]         DATA_LEN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               Data_Valid,
  output logic               Parity_Error,
  output logic               Stop_Error,
  output logic               Break_Det
);

  logic [SYNC_ST-1:0] sync_q;
  logic               rx_s;
  state_t             state;
  state_t             state_n;
  cfg_t               cfg_in;
  cfg_t               cfg_q;
  logic [3:0]         bit_cnt;
  logic               stop_cnt;
  logic               any_one;
  logic               stop_bad;
  logic               par_bit;
  logic [DATA_W-1:0]  data_q;
  logic               arm;
  logic               bit_val;
  logic               bit_stb;
  logic               last_data;
  logic               par_err;
  logic               is_break;

  // Reset to idle-high so the synchroniser never fakes a start edge
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_ST-2:0], RX_IN};
  end
  assign rx_s = sync_q[SYNC_ST-1];

  assign cfg_in    = '{data_len: DATA_LEN, par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};
  assign arm       = (state == IDLE) || (state == BRK_WAIT);
  assign last_data = (bit_cnt == 4'(MIN_DATA_BITS - 1) + 4'(cfg_q.data_len));
  assign is_break  = !any_one;
  assign par_err   = cfg_q.par_en && (par_bit != (^data_q ^ cfg_q.par_typ));

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .rx_s     (rx_s),
    .arm      (arm),
    .prescale (Prescale),
    .bit_val  (bit_val),
    .bit_stb  (bit_stb)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!rx_s) state_n = START;
      START:    if (bit_stb) state_n = bit_val ? IDLE : DATA;
      DATA:     if (bit_stb && last_data) state_n = cfg_q.par_en ? PARITY : STOP;
      PARITY:   if (bit_stb) state_n = STOP;
      STOP:     if (bit_stb && !(cfg_q.stop2 && !stop_cnt)) state_n = DONE;
      DONE:     state_n = is_break ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      any_one      <= 1'b0;
      stop_bad     <= 1'b0;
      par_bit      <= 1'b0;
      data_q       <= '0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Break_Det    <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Break_Det    <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          any_one  <= 1'b0;
          stop_bad <= 1'b0;
          par_bit  <= 1'b0;
          data_q   <= '0;
          if (!rx_s) cfg_q <= cfg_in;
        end
        DATA: if (bit_stb) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (i == int'(bit_cnt)) data_q[i] <= bit_val;
          end
          bit_cnt <= bit_cnt + 4'd1;
          any_one <= any_one | bit_val;
        end
        PARITY: if (bit_stb) begin
          par_bit <= bit_val;
          any_one <= any_one | bit_val;
        end
        STOP: if (bit_stb) begin
          stop_cnt <= 1'b1;
          any_one  <= any_one | bit_val;
          if (!bit_val) stop_bad <= 1'b1;
        end
        DONE: begin
          // A break masks every other verdict for this frame
          Break_Det    <= is_break;
          Parity_Error <= !is_break && par_err;
          Stop_Error   <= !is_break && stop_bad;
          Data_Valid   <= !is_break && !par_err && !stop_bad;
          if (!is_break && !par_err && !stop_bad) P_DATA <= data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised self-checking bench for uart_rx_cfg against a frame-level reference model.
// Frames are built as bit lists; outcomes are derived from those lists, not from DUT state.
module tb_uart_rx_cfg;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;
  localparam int SYNC_ST = 2;

  logic               CLK = 1'b0;
  logic               RST;
  logic               RX_IN;
  logic [PRESC_W-1:0] Prescale;
  logic [1:0]         DATA_LEN;
  logic               PAR_EN, PAR_TYP, STOP2;
  logic [DATA_W-1:0]  P_DATA;
  logic               Data_Valid, Parity_Error, Stop_Error, Break_Det;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, bk_cnt = 0, flag_edge = 0;
  logic [7:0] dv_q[$];

  int b_dv, b_pe, b_se, b_bk;
  int e_dv, e_pe, e_se, e_bk, e_lat, start_edge;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx_cfg #(.DATA_W(DATA_W), .PRESC_W(PRESC_W), .SYNC_ST(SYNC_ST)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
    .Break_Det(Break_Det)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n <= edge_n + 1;

  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt <= dv_cnt + 1;
      dv_q.push_back(P_DATA);
    end
    if (Parity_Error) pe_cnt <= pe_cnt + 1;
    if (Stop_Error)   se_cnt <= se_cnt + 1;
    if (Break_Det)    bk_cnt <= bk_cnt + 1;
    if (Data_Valid || Parity_Error || Stop_Error || Break_Det) flag_edge <= edge_n;
  end

  function automatic logic [31:0] obs_flags();
    return {8'(dv_cnt - b_dv), 8'(pe_cnt - b_pe), 8'(se_cnt - b_se), 8'(bk_cnt - b_bk)};
  endfunction

  function automatic logic [31:0] exp_flags();
    return {8'(e_dv), 8'(e_pe), 8'(e_se), 8'(e_bk)};
  endfunction

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic snapshot();
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_bk = bk_cnt;
  endtask

  // corrupt: 0 none, 1 flip tap P/2+1 in every bit, 2 flip one random tap per bit
  task automatic send_frame(input logic [7:0] data, input logic [1:0] dlen, input logic pen,
                            input logic ptyp, input logic st2, input logic flip_par,
                            input logic bad_stop, input int p, input int corrupt,
                            input bit scramble, input bit brk, input int tail_low);
    bit bits[$];
    int nb, nbits, tap;
    logic [7:0] masked, rx_data;
    bit nonzero, stop_ok, par_ok, v;
    nb = 5 + int'(dlen);
    masked = data & 8'((1 << nb) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(brk ? 1'b0 : masked[i]);
    if (pen) bits.push_back(brk ? 1'b0 : ((^masked) ^ ptyp ^ flip_par));
    bits.push_back(brk ? 1'b0 : 1'b1);
    if (st2) bits.push_back(brk ? 1'b0 : !bad_stop);
    nbits = bits.size();
    rx_data = 8'h00;
    for (int i = 0; i < nb; i++) rx_data[i] = bits[1 + i];
    nonzero = 1'b0;
    for (int k = 1; k < nbits; k++) nonzero |= bits[k];
    stop_ok = 1'b1;
    for (int k = 1 + nb + (pen ? 1 : 0); k < nbits; k++) stop_ok &= bits[k];
    par_ok = !pen || (bits[1 + nb] == ((^rx_data) ^ ptyp));
    e_bk  = nonzero ? 0 : 1;
    e_pe  = (nonzero && !par_ok) ? 1 : 0;
    e_se  = (nonzero && !stop_ok) ? 1 : 0;
    e_dv  = (nonzero && par_ok && stop_ok) ? 1 : 0;
    if (e_dv == 1) exp_pdata = rx_data;
    e_lat = 2 + (nbits - 1) * p + p / 2 + 2;

    snapshot();
    Prescale = PRESC_W'(p);
    DATA_LEN = dlen; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2;
    start_edge = edge_n + 1;
    for (int k = 0; k < nbits; k++) begin
      tap = (corrupt == 1) ? p / 2 + 1 : p / 2 - 1 + int'($urandom_range(0, 2));
      for (int c = 0; c < p; c++) begin
        v = bits[k];
        if (corrupt != 0 && c == tap) v = !v;
        RX_IN = v;
        if (scramble && k == 2 && c == 0) begin
          DATA_LEN = 2'($urandom); PAR_EN = 1'($urandom);
          PAR_TYP = 1'($urandom);  STOP2 = 1'($urandom);
        end
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = (tail_low > 0) ? 1'b0 : 1'b1;
    settle(tail_low);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1;
    settle(3);
    n_checks++;
    if ({P_DATA, Data_Valid, Parity_Error, Stop_Error, Break_Det} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 000",
               {P_DATA, Data_Valid, Parity_Error, Stop_Error, Break_Det});
    end
    RST = 1'b0;
    snapshot();
    settle(20);
    e_dv = 0; e_pe = 0; e_se = 0; e_bk = 0;
    n_checks++;
    if (obs_flags() !== exp_flags()) begin
      n_fail++;
      $display("FAIL reset_idle_flags got %h want %h", obs_flags(), exp_flags());
    end
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0, 1'b0, 0);
    settle(20);
    n_checks++;
    if (obs_flags() !== exp_flags()) begin
      n_fail++; $display("FAIL 8n1_flags got %h want %h", obs_flags(), exp_flags());
    end
    n_checks++;
    if (P_DATA !== 8'hA5) begin
      n_fail++; $display("FAIL 8n1_data got %h want a5", P_DATA);
    end
    n_checks++;
    if (flag_edge - start_edge !== 80) begin
      n_fail++; $display("FAIL 8n1_latency got %0d want 80", flag_edge - start_edge);
    end
  endtask

  task automatic test_7e2();
    send_frame(8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16, 0, 1'b0, 1'b0, 0);
    settle(40);
    n_checks++;
    if (obs_flags() !== exp_flags() || P_DATA !== 8'h35) begin
      n_fail++; $display("FAIL 7e2_good got %h/%h want %h/35", obs_flags(), P_DATA, exp_flags());
    end
    n_checks++;
    if (flag_edge - start_edge !== e_lat) begin
      n_fail++; $display("FAIL 7e2_latency got %0d want %0d", flag_edge - start_edge, e_lat);
    end
    send_frame(8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16, 0, 1'b0, 1'b0, 0);
    settle(40);
    n_checks++;
    if (obs_flags() !== 32'h0001_0000) begin
      n_fail++; $display("FAIL 7e2_parity_flags got %h want 00010000", obs_flags());
    end
    n_checks++;
    if (P_DATA !== exp_pdata) begin
      n_fail++; $display("FAIL 7e2_parity_hold got %h want %h", P_DATA, exp_pdata);
    end
  endtask

  task automatic test_stop_err();
    send_frame(8'h1F, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8, 0, 1'b0, 1'b0, 0);
    settle(20);
    n_checks++;
    if (obs_flags() !== 32'h0000_0100) begin
      n_fail++; $display("FAIL stop_err_flags got %h want 00000100", obs_flags());
    end
    n_checks++;
    if (P_DATA !== exp_pdata || flag_edge - start_edge !== e_lat) begin
      n_fail++;
      $display("FAIL stop_err_hold got %h lat %0d want %h lat %0d",
               P_DATA, flag_edge - start_edge, exp_pdata, e_lat);
    end
  endtask

  task automatic test_glitch();
    snapshot();
    Prescale = PRESC_W'(16);
    RX_IN = 1'b0;
    settle(3);
    RX_IN = 1'b1;
    settle(60);
    n_checks++;
    if (obs_flags() !== 32'h0) begin
      n_fail++; $display("FAIL glitch_flags got %h want 00000000", obs_flags());
    end
    send_frame(8'h6E, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16, 0, 1'b0, 1'b0, 0);
    settle(40);
    n_checks++;
    if (obs_flags() !== exp_flags() || P_DATA !== 8'h6E) begin
      n_fail++; $display("FAIL glitch_next got %h/%h want %h/6e", obs_flags(), P_DATA, exp_flags());
    end
  endtask

  task automatic test_majority();
    send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1, 1'b0, 1'b0, 0);
    settle(40);
    n_checks++;
    if (obs_flags() !== 32'h0100_0000 || P_DATA !== 8'h3C) begin
      n_fail++; $display("FAIL majority got %h/%h want 01000000/3c", obs_flags(), P_DATA);
    end
  endtask

  task automatic test_break();
    logic [7:0] held;
    held = exp_pdata;
    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0, 1'b1, 20 * 8);
    settle(20);
    n_checks++;
    if (obs_flags() !== 32'h0000_0001) begin
      n_fail++; $display("FAIL break_flags got %h want 00000001", obs_flags());
    end
    n_checks++;
    if (P_DATA !== held || flag_edge - start_edge !== e_lat) begin
      n_fail++;
      $display("FAIL break_hold got %h lat %0d want %h lat %0d",
               P_DATA, flag_edge - start_edge, held, e_lat);
    end
    send_frame(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0, 1'b0, 0);
    settle(20);
    n_checks++;
    if (obs_flags() !== 32'h0100_0000 || P_DATA !== 8'h81) begin
      n_fail++; $display("FAIL break_release got %h/%h want 01000000/81", obs_flags(), P_DATA);
    end
  endtask

  task automatic test_rst_mid();
    snapshot();
    Prescale = PRESC_W'(8); DATA_LEN = 2'd3; PAR_EN = 1'b0; STOP2 = 1'b0;
    RX_IN = 1'b0;
    settle(8 * 3 + 2);
    RST = 1'b1;
    settle(1);
    RST = 1'b0; RX_IN = 1'b1;
    exp_pdata = 8'h00;
    settle(30);
    n_checks++;
    if (obs_flags() !== 32'h0 || P_DATA !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid got %h/%h want 00000000/00", obs_flags(), P_DATA);
    end
    send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0, 1'b0, 0);
    settle(20);
    n_checks++;
    if (obs_flags() !== 32'h0100_0000 || P_DATA !== 8'h5A) begin
      n_fail++; $display("FAIL rst_mid_next got %h/%h want 01000000/5a", obs_flags(), P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int base_q, t_dv, t_pe, t_se, t_bk, s_dv, s_pe, s_se, s_bk, p;
    logic bad_stop, st2;
    base_q = dv_q.size();
    s_dv = dv_cnt; s_pe = pe_cnt; s_se = se_cnt; s_bk = bk_cnt;
    t_dv = 0; t_pe = 0; t_se = 0; t_bk = 0;
    for (int n = 0; n < 14; n++) begin
      p = 8 + 4 * int'($urandom_range(0, 2));
      st2 = 1'($urandom);
      bad_stop = st2 && ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), st2,
                 1'($urandom_range(0, 3) == 0), bad_stop, p, 2, 1'b1, 1'b0, 0);
      t_dv += e_dv; t_pe += e_pe; t_se += e_se; t_bk += e_bk;
      if (e_dv == 1) exp_q.push_back(exp_pdata);
      if (bad_stop) settle(p);
    end
    settle(40);
    n_checks++;
    if ({8'(dv_cnt - s_dv), 8'(pe_cnt - s_pe), 8'(se_cnt - s_se), 8'(bk_cnt - s_bk)} !==
        {8'(t_dv), 8'(t_pe), 8'(t_se), 8'(t_bk)}) begin
      n_fail++;
      $display("FAIL b2b_counts got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               dv_cnt - s_dv, pe_cnt - s_pe, se_cnt - s_se, bk_cnt - s_bk,
               t_dv, t_pe, t_se, t_bk);
    end
    for (int i = 0; i < exp_q.size() && base_q + i < dv_q.size(); i++) begin
      n_checks++;
      if (dv_q[base_q + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, dv_q[base_q + i], exp_q[i]);
      end
    end
    n_checks++;
    if (P_DATA !== exp_pdata) begin
      n_fail++; $display("FAIL b2b_final got %h want %h", P_DATA, exp_pdata);
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; Prescale = PRESC_W'(8);
    DATA_LEN = 2'd3; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_stop_err();
    test_glitch();
    test_majority();
    test_break();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
